srl_fifo_ctrl: RTL

Parametrised shift-register FIFO with an HLS-style handshake. It replaces the fixed 1-bit, 4-deep start-token FIFOs between dataflow processes with one block that covers any data width, any depth, an optional registered output stage, and an occupancy/almost-full report. Storage is an addressable SRL array; this block adds the pointer, flags, counter and output stage around it.

---
 rtl/srl_fifo_pkg.sv | 25 ++
 rtl/srl_fifo_shiftreg.sv | 31 +++
 rtl/srl_fifo_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/srl_fifo_pkg.sv
// Shared constants and elaboration-time helpers for the SRL FIFO controller.
`timescale 1ns/1ps
package srl_fifo_pkg;

  // Smallest r with 2**r >= n; bounded loop so it stays a constant function.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  function automatic int fifo_cap(input int depth, input int out_reg);
    return depth + ((out_reg != 0) ? 1 : 0);
  endfunction

  function automatic int count_width(input int addr_width);
    return addr_width + 2;
  endfunction

endpackage

// File: rtl/srl_fifo_shiftreg.sv
// Addressable shift-register storage: shifts in at entry 0 on we, reads any entry combinationally.
`timescale 1ns/1ps
module srl_fifo_shiftreg
  import srl_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Shift chain; contents are deliberately not reset so it maps onto SRL primitives.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        mem_q[i] <= mem_q[i-1];
      end
      mem_q[0] <= din;
    end
  end

  assign dout = mem_q[addr];

endmodule

// File: rtl/srl_fifo_ctrl.sv
// Pointer, flags, occupancy counter and optional FWFT output register around the SRL array.
`timescale 1ns/1ps
module srl_fifo_ctrl
  import srl_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int OUT_REG    = 0,
  parameter int AF_LEVEL   = DEPTH - 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH+1:0] if_num_data_valid,
  output logic                  if_almost_full
);

  localparam int CW = count_width(ADDR_WIDTH);
  // One extra pointer bit keeps "empty" (all-ones) distinct from the last entry.
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] CAP_C     = CW'(fifo_cap(DEPTH, OUT_REG));
  localparam logic [CW-1:0] AF_C      = CW'(AF_LEVEL);
  localparam logic [PW-1:0] PTR_EMPTY = {PW{1'b1}};

  logic                  push_s;
  logic                  pop_s;
  logic                  drain_s;
  logic                  srl_empty_s;
  logic [DATA_WIDTH-1:0] srl_dout_s;

  logic [PW-1:0]         ptr_q,     ptr_d;
  logic [CW-1:0]         count_q,   count_d;
  logic                  full_n_q,  full_n_d;
  logic                  empty_n_q, empty_n_d;
  logic                  af_q,      af_d;
  logic                  ov_q,      ov_d;
  logic [DATA_WIDTH-1:0] oreg_q,    oreg_d;

  srl_fifo_shiftreg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk  (clk),
    .we   (push_s),
    .addr (ptr_q[ADDR_WIDTH-1:0]),
    .din  (if_din),
    .dout (srl_dout_s)
  );

  assign srl_empty_s = (ptr_q == PTR_EMPTY);
  assign pop_s       = if_read & empty_n_q;
  // A pop frees a slot in the same cycle, so a full FIFO still takes a simultaneous write.
  assign push_s      = if_write & (full_n_q | pop_s);

  // Next-state for pointer, counter, flags and output stage.
  always_comb begin
    drain_s   = 1'b0;
    ptr_d     = ptr_q;
    count_d   = count_q;
    oreg_d    = oreg_q;
    ov_d      = ov_q;

    if (OUT_REG != 0) begin
      drain_s = ~srl_empty_s & (~ov_q | pop_s);
    end else begin
      drain_s = pop_s;
    end

    case ({push_s, drain_s})
      2'b10:   ptr_d = ptr_q + {{(PW-1){1'b0}}, 1'b1};
      2'b01:   ptr_d = ptr_q - {{(PW-1){1'b0}}, 1'b1};
      default: ptr_d = ptr_q;
    endcase

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase

    if (OUT_REG != 0) begin
      if (drain_s) begin
        oreg_d = srl_dout_s;
        ov_d   = 1'b1;
      end else if (pop_s) begin
        oreg_d = oreg_q;
        ov_d   = 1'b0;
      end else begin
        oreg_d = oreg_q;
        ov_d   = ov_q;
      end
    end else begin
      oreg_d = oreg_q;
      ov_d   = 1'b0;
    end

    if (OUT_REG != 0) begin
      empty_n_d = ov_d;
    end else begin
      empty_n_d = (ptr_d != PTR_EMPTY);
    end

    full_n_d = (count_d != CAP_C);
    af_d     = (count_d >= AF_C);
  end

  // Control state with asynchronous clear; queued data is discarded by resetting the pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q     <= PTR_EMPTY;
      count_q   <= {CW{1'b0}};
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
      af_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
      af_q      <= af_d;
      ov_q      <= ov_d;
    end
  end

  // Output data register has no reset; its contents only matter while ov is set.
  always_ff @(posedge clk) begin
    oreg_q <= oreg_d;
  end

  assign if_full_n         = full_n_q;
  assign if_empty_n        = empty_n_q;
  assign if_num_data_valid = count_q;
  assign if_almost_full    = af_q;
  assign if_dout           = (OUT_REG != 0) ? oreg_q : srl_dout_s;

endmodule
